// File: rtl/debounce_bank_pkg.sv
// Shared definitions for the push-button conditioner bank: per-channel FSM
// states and the helper that sizes the shared cycle counter.
package debounce_bank_pkg;

    // Channel states: released, press check, pressed, auto-repeating, release check.
    typedef enum logic [2:0] {
        REL  = 3'd0,
        PCHK = 3'd1,
        PRS  = 3'd2,
        RPT  = 3'd3,
        RCHK = 3'd4
    } state_t;

    // Largest of the three timing constants; the counter must reach its value minus one.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button bank bus: raw inputs and repeat enables in, conditioned levels and
// strobes out. The DUT side uses the slave modport.
// "release" is a SystemVerilog keyword, hence the i_/o_ prefixed names.
interface debounce_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] i_in;
    logic [N-1:0] i_rep_en;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic [N-1:0] o_rpt;

    modport master (
        output i_in, i_rep_en,
        input  o_level, o_press, o_release, o_rpt
    );

    modport slave (
        input  i_in, i_rep_en,
        output o_level, o_press, o_release, o_rpt
    );
endinterface

// File: rtl/debounce_bank_chan.sv
// One button channel: 2-FF synchroniser, debounce/hold/repeat counter,
// five-state FSM and registered level and strobe outputs.
module debounce_bank_chan
    import debounce_bank_pkg::*;
#(
    parameter int DB_CYC   = 650000,
    parameter int HOLD_CYC = 25000000,
    parameter int RPT_CYC  = 5000000,
    parameter bit ACT_LOW  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    input  logic i_rep_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_rpt
);

    localparam int CNT_W = $clog2(max3(DB_CYC, HOLD_CYC, RPT_CYC));
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

    logic             r_s1, r_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_level, w_level_nxt;
    logic             r_press, w_press_nxt;
    logic             r_release, w_release_nxt;
    logic             r_rpt, w_rpt_nxt;

    // Bring the raw button into the clock domain, normalised to 1 = pressed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so r_s2 takes the old r_s1 and both flops really form a chain.
            r_s1 <= i_in ^ ACT_LOW;
            r_s2 <= r_s1;
        end
    end

    // Next state, counter and outputs; the counter is cleared on every state change.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_rpt_nxt     = 1'b0;
        case (r_state)
            REL: begin
                w_cnt_nxt = '0;
                if (r_s2) w_state_nxt = PCHK;
            end
            PCHK: begin
                if (!r_s2) begin
                    w_state_nxt = REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRS: begin
                if (!r_s2) begin
                    w_state_nxt = RCHK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    // Without rep_en the counter parks here until repeat is enabled.
                    if (i_rep_en) begin
                        w_state_nxt = RPT;
                        w_cnt_nxt   = '0;
                        w_rpt_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RPT: begin
                if (!r_s2) begin
                    w_state_nxt = RCHK;
                    w_cnt_nxt   = '0;
                end else if (!i_rep_en) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == RPT_LAST) begin
                    w_cnt_nxt = '0;
                    w_rpt_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RCHK: begin
                if (r_s2) begin
                    w_state_nxt = PRS;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt   = REL;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = REL;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset drops level without a release strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rpt     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_rpt     <= w_rpt_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_rpt     = r_rpt;

endmodule

// File: rtl/debounce_bank.sv
// N independent button channels behind one bus interface.
module debounce_bank #(
    parameter int N        = 4,
    parameter int DB_CYC   = 650000,
    parameter int HOLD_CYC = 25000000,
    parameter int RPT_CYC  = 5000000,
    parameter bit ACT_LOW  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    debounce_bank_if.slave bus
);

    logic [N-1:0] w_level;
    logic [N-1:0] w_press;
    logic [N-1:0] w_release;
    logic [N-1:0] w_rpt;

    for (genvar g = 0; g < N; g++) begin : g_chan
        debounce_bank_chan #(
            .DB_CYC   (DB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .RPT_CYC  (RPT_CYC),
            .ACT_LOW  (ACT_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_in      (bus.i_in[g]),
            .i_rep_en  (bus.i_rep_en[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_rpt     (w_rpt[g])
        );
    end

    assign bus.o_level   = w_level;
    assign bus.o_press   = w_press;
    assign bus.o_release = w_release;
    assign bus.o_rpt     = w_rpt;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench: a 2-channel active-high bank and a 1-channel active-low bank
// with short timing constants, checked against hand-derived edge numbers.
module tb_debounce_bank;

    localparam int N    = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    debounce_bank_if #(.N(N)) u_if_a ();
    debounce_bank_if #(.N(1)) u_if_b ();

    debounce_bank #(
        .N(N), .DB_CYC(DB), .HOLD_CYC(HOLD), .RPT_CYC(RPT), .ACT_LOW(1'b0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (u_if_a.slave)
    );

    debounce_bank #(
        .N(1), .DB_CYC(DB), .HOLD_CYC(HOLD), .RPT_CYC(RPT), .ACT_LOW(1'b1)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (u_if_b.slave)
    );

    // Observed outputs packed as {level, press, release, rpt}.
    wire [7:0] obs_a = {u_if_a.o_level, u_if_a.o_press, u_if_a.o_release, u_if_a.o_rpt};
    wire [3:0] obs_b = {u_if_b.o_level, u_if_b.o_press, u_if_b.o_release, u_if_b.o_rpt};

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] lvl, prs;
        logic [7:0] exp;
        rst             = 1'b1;
        u_if_a.i_in     = 2'b11;
        u_if_a.i_rep_en = 2'b00;
        u_if_b.i_in     = 1'b1;
        u_if_b.i_rep_en = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (obs_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a: got lvl/prs/rel/rpt=%b expected %b", obs_a, 8'h00);
        end
        n_vec++;
        if (obs_b !== 4'h0) begin
            n_err++;
            $display("FAIL reset_b: got lvl/prs/rel/rpt=%b expected %b", obs_b, 4'h0);
        end
        // Release reset and hold channel 0; the next edge is sampling edge 0.
        u_if_a.i_in = 2'b01;
        rst         = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lvl = (k >= 7) ? 2'b01 : 2'b00;
            prs = (k == 7) ? 2'b01 : 2'b00;
            exp = {lvl, prs, 2'b00, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL first_press step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_release();
        logic [1:0] lvl, rel;
        logic [7:0] exp;
        // Two-cycle release glitch: level must stay up with no release strobe.
        for (int k = 1; k <= 10; k++) begin
            u_if_a.i_in[0] = (k <= 2) ? 1'b0 : 1'b1;
            tick();
            exp = {2'b01, 2'b00, 2'b00, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL release_glitch step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
        // Real release.
        u_if_a.i_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lvl = (k < 7) ? 2'b01 : 2'b00;
            rel = (k == 7) ? 2'b01 : 2'b00;
            exp = {lvl, 2'b00, rel, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL release step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_bounce();
        // Three-cycle press pulse is shorter than the debounce window.
        for (int k = 1; k <= 12; k++) begin
            u_if_a.i_in[0] = (k <= 3) ? 1'b1 : 1'b0;
            tick();
            n_vec++;
            if (obs_a !== 8'h00) begin
                n_err++;
                $display("FAIL press_bounce step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, 8'h00);
            end
        end
    endtask

    task automatic test_repeat();
        logic [1:0] lvl, prs, rel, rpt;
        logic [7:0] exp;
        u_if_a.i_rep_en = 2'b01;
        u_if_a.i_in[0]  = 1'b1;
        // Press at step 7 (t); repeats at t+10, t+13, t+16.
        for (int k = 1; k <= 24; k++) begin
            tick();
            lvl = (k >= 7) ? 2'b01 : 2'b00;
            prs = (k == 7) ? 2'b01 : 2'b00;
            rpt = (k == 17 || k == 20 || k == 23) ? 2'b01 : 2'b00;
            exp = {lvl, prs, 2'b00, rpt};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL repeat step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
        // Dropping rep_en one edge after a repeat stops further strobes.
        u_if_a.i_rep_en = 2'b00;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp = {2'b01, 2'b00, 2'b00, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL repeat_off step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
        u_if_a.i_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lvl = (k < 7) ? 2'b01 : 2'b00;
            rel = (k == 7) ? 2'b01 : 2'b00;
            exp = {lvl, 2'b00, rel, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL repeat_release step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
    endtask

    task automatic test_both_and_reset();
        logic [1:0] lvl, prs;
        logic [7:0] exp;
        u_if_a.i_in = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lvl = (k >= 7) ? 2'b11 : 2'b00;
            prs = (k == 7) ? 2'b11 : 2'b00;
            exp = {lvl, prs, 2'b00, 2'b00};
            n_vec++;
            if (obs_a !== exp) begin
                n_err++;
                $display("FAIL both_press step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, exp);
            end
        end
        repeat (3) tick();
        // Asynchronous reset mid-hold: level drops before the next clock edge.
        rst = 1'b1;
        #1;
        n_vec++;
        if (obs_a !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_hold: got lvl/prs/rel/rpt=%b expected %b", obs_a, 8'h00);
        end
        u_if_a.i_in = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_vec++;
            if (obs_a !== 8'h00) begin
                n_err++;
                $display("FAIL reset_held step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, 8'h00);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (obs_a !== 8'h00) begin
                n_err++;
                $display("FAIL after_reset step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_a, 8'h00);
            end
        end
    endtask

    task automatic test_act_low();
        logic       lvl, prs;
        logic [3:0] exp;
        u_if_b.i_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            lvl = (k >= 7);
            prs = (k == 7);
            exp = {lvl, prs, 1'b0, 1'b0};
            n_vec++;
            if (obs_b !== exp) begin
                n_err++;
                $display("FAIL act_low_press step %0d: got lvl/prs/rel/rpt=%b expected %b", k, obs_b, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_bounce();
        test_repeat();
        test_both_and_reset();
        test_act_low();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
